fft_frame_feeder: RTL and testbench

Streaming source for the 64-point pipelined FFT. It accepts complex samples over a valid/ready handshake and collects each frame in a ping-pong buffer. It then drives the FFT input port as an unbroken stream, including the FFT reset-release (`fft_nrst`). The FFT pipeline cannot pause once released, so at any frame boundary with no complete frame buffered, the feeder inserts a zero-valued filler frame and flags it.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_pingpong_buf.sv | 75 +++++++
 rtl/fft_frame_feeder.sv | 135 +++++++++++++
 tb/tb_fft_frame_feeder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT front-end types and constants.
// Frame geometry, complex sample layout and feeder states.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef enum logic {
    FEED_IDLE,
    FEED_STREAM
  } feed_state_e;

endpackage

// File: rtl/fft_pingpong_buf.sv
// Two-bank frame store with full flags and bank pointers.
// Writer fills banks in turn; reader releases them in turn.
module fft_pingpong_buf
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [DW-1:0]        wr_data_i,
  output logic                 wr_ready_o,
  input  logic [$clog2(N)-1:0] rd_addr_i,
  output logic [DW-1:0]        rd_data_o,
  output logic                 rd_full_o,
  input  logic                 rel_i
);

  localparam int AW = $clog2(N);

  logic [DW-1:0] mem_q [2*N];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_fire;

  assign wr_ready_o = !rst && !full_q[wr_bank_q];
  assign wr_fire    = wr_en_i && wr_ready_o;
  assign rd_data_o  = mem_q[{rd_bank_q, rd_addr_i}];
  assign rd_full_o  = full_q[rd_bank_q];

  // Pointer and flag next-state; fill and release touch different banks.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == AW'(N - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rel_i) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Control state; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[{wr_bank_q, wr_cnt_q}] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Frame feeder: buffers input frames, streams them unbroken to the FFT.
// Build option FEEDER_CONJ_EN conjugates samples on the write path.
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          fft_nrst,
  output logic [DW-1:0] fft_data,
  output logic          frame_start,
  output logic          filler,
  output logic          underrun
);

  localparam int AW = $clog2(N);

  feed_state_e   state_q, state_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          nrst_q, nrst_d;
  logic          fs_q, fs_d;
  logic          fill_q, fill_d;
  logic          ur_q, ur_d;
  logic          rel;
  logic          rd_full;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] wr_data;

`ifdef FEEDER_CONJ_EN
  cplx_t in_c, wr_c;

  assign in_c = s_data;

  // Conjugate on entry; -32768 has no positive twin so it clamps.
  always_comb begin
    wr_c = in_c;
    if (in_c.im == 16'sh8000) wr_c.im = 16'sh7fff;
    else                      wr_c.im = -in_c.im;
  end

  assign wr_data = wr_c;
`else
  assign wr_data = s_data;
`endif

  fft_pingpong_buf #(
    .N  (N),
    .DW (DW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (s_valid),
    .wr_data_i  (wr_data),
    .wr_ready_o (s_ready),
    .rd_addr_i  (rd_cnt_q),
    .rd_data_o  (rd_data),
    .rd_full_o  (rd_full),
    .rel_i      (rel)
  );

  // Next-state: start on first full bank, then pick real/filler per frame.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    data_d   = data_q;
    nrst_d   = nrst_q;
    fs_d     = 1'b0;
    fill_d   = fill_q;
    ur_d     = 1'b0;
    rel      = 1'b0;
    unique case (state_q)
      FEED_IDLE: begin
        data_d   = '0;
        nrst_d   = 1'b0;
        fill_d   = 1'b0;
        rd_cnt_d = '0;
        if (rd_full) begin
          state_d  = FEED_STREAM;
          data_d   = rd_data;
          nrst_d   = 1'b1;
          fs_d     = 1'b1;
          rd_cnt_d = AW'(1);
        end
      end
      FEED_STREAM: begin
        nrst_d   = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == '0) begin
          fs_d   = 1'b1;
          fill_d = !rd_full;
          ur_d   = !rd_full;
          data_d = rd_full ? rd_data : '0;
        end else begin
          data_d = fill_q ? '0 : rd_data;
          rel    = !fill_q && (rd_cnt_q == AW'(N - 1));
        end
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  // Registered state and FFT-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FEED_IDLE;
      rd_cnt_q <= '0;
      data_q   <= '0;
      nrst_q   <= 1'b0;
      fs_q     <= 1'b0;
      fill_q   <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      data_q   <= data_d;
      nrst_q   <= nrst_d;
      fs_q     <= fs_d;
      fill_q   <= fill_d;
      ur_q     <= ur_d;
    end
  end

  assign fft_nrst    = nrst_q;
  assign fft_data    = data_q;
  assign frame_start = fs_q;
  assign filler      = fill_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: directed stimulus, scoreboard of frames.
// Honours FEEDER_CONJ_EN in the expected sample values.
module tb_fft_frame_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        fft_nrst;
  logic [31:0] fft_data;
  logic        frame_start;
  logic        filler;
  logic        underrun;

  int vectors = 0;
  int miscompares = 0;

  fft_frame_feeder #(
    .N  (64),
    .DW (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .fft_nrst    (fft_nrst),
    .fft_data    (fft_data),
    .frame_start (frame_start),
    .filler      (filler),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cj(input logic [31:0] d);
    logic [31:0] r;
    r = d;
`ifdef FEEDER_CONJ_EN
    if (d[15:0] == 16'h8000) r[15:0] = 16'h7fff;
    else                     r[15:0] = 16'h0000 - d[15:0];
`endif
    return r;
  endfunction

  // Scoreboard state: accepted samples and edges where frames completed.
  int          cyc = 0;
  logic        last_rst = 1'b1;
  logic [31:0] sq[$];
  int          fq[$];
  int          wcnt = 0;
  logic        es = 1'b0;
  int          ep = 0;
  logic        ef = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon
    logic [35:0] e;
    logic [35:0] o;
    logic        rdy;
    if (cyc > 0) begin
      rdy = (fq.size() > 0) && (fq[0] <= cyc - 1);
      e = '0;
      if (last_rst) begin
        es = 1'b0;
      end else if (!es) begin
        if (rdy) begin
          es = 1'b1;
          ep = 0;
          ef = 1'b0;
          void'(fq.pop_front());
          e[35:32] = 4'b1100;
          e[31:0] = (sq.size() > 0) ? sq.pop_front() : 32'hdeadbeef;
        end
      end else begin
        ep = (ep + 1) % 64;
        if (ep == 0) begin
          ef = !rdy;
          if (rdy) void'(fq.pop_front());
        end
        e[35] = 1'b1;
        e[34] = (ep == 0);
        e[33] = ef;
        e[32] = ef && (ep == 0);
        if (!ef) e[31:0] = (sq.size() > 0) ? sq.pop_front() : 32'hdeadbeef;
      end
      o = {fft_nrst, frame_start, filler, underrun, fft_data};
      chk($sformatf("out@%0d", cyc), 64'(o), 64'(e));
    end
    last_rst = rst;
    if (rst) begin
      sq.delete();
      fq.delete();
      wcnt = 0;
    end else if (s_valid && s_ready) begin
      sq.push_back(cj(s_data));
      wcnt++;
      if (wcnt == 64) begin
        fq.push_back(cyc + 1);
        wcnt = 0;
      end
    end
  end

  task automatic send(input logic [31:0] d);
    logic ok;
    int   n;
    s_data  = d;
    s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 300);
    #1 s_valid = 1'b0;
    if (!ok) chk("send_tmo", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_in_rst", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rdy_after_rst", 64'(s_ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    do_rst();
    // ramp frame, then starve: fillers follow
    for (int k = 0; k < 64; k++) send({k[15:0], 16'h0000});
    idle(140);
    // sustained input: 3 frames plus 10 samples
    do_rst();
    for (int i = 0; i < 202; i++) send($urandom);
    idle(260);
    // reset during frame 2, then a fresh frame
    do_rst();
    for (int i = 0; i < 128; i++) send(32'h1000_0000 | 32'(i));
    idle(30);
    do_rst();
    for (int i = 0; i < 64; i++) send(32'ha500_0000 | 32'(i));
    idle(80);
    // second bank completes at filler sample 20
    do_rst();
    for (int i = 0; i < 64; i++) send(32'h2000_0000 | 32'(i));
    idle(21);
    for (int i = 0; i < 64; i++) send(32'h3000_0000 | 32'(i));
    idle(130);
    // conjugation corner values, gappy producer
    do_rst();
    send(32'h0100_8000);
    send(32'h0100_0005);
    for (int i = 0; i < 62; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send($urandom);
    end
    idle(80);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
